// File: rtl/apb_irq_master_pkg.sv
// Shared encodings for the APB IRQ master: transfer phases, op sources, status register layout.
package apb_irq_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  typedef enum logic [1:0] {
    OP_CMD    = 2'd0,
    OP_SVC_RD = 2'd1,
    OP_SVC_WR = 2'd2
  } op_e;

  localparam logic [7:0] STATUS_ADDR_DEF = 8'h04;
  localparam int         PEND_LSB        = 4;
  localparam int         PEND_W          = 4;

endpackage

// File: rtl/apb_irq_master_xfer.sv
// Single APB transfer engine: SETUP, ACCESS with optional timeout, then one idle GAP cycle.
module apb_irq_master_xfer
  import apb_irq_master_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              idle_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [31:0]       pwdata_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        st_q, st_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;
  logic              tmo_hit;

  // cnt_q holds the number of ACCESS cycles already spent without pready
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    wr_d   = wr_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    err_d  = err_q;
    case (st_q)
      ST_IDLE: begin
        if (start_i) begin
          st_d   = ST_SETUP;
          addr_d = addr_i;
          wr_d   = write_i;
          wd_d   = wdata_i;
        end
      end
      ST_SETUP: begin
        st_d  = ST_ACCESS;
        cnt_d = '0;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          st_d  = ST_GAP;
          err_d = pslverr_i;
          rd_d  = (wr_q || pslverr_i) ? 32'h0 : prdata_i;
        end else if (tmo_hit) begin
          st_d  = ST_GAP;
          err_d = 1'b1;
          rd_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  // Bus strobes decode straight from the state so reset drops them immediately
  assign psel_o    = (st_q == ST_SETUP) || (st_q == ST_ACCESS);
  assign penable_o = (st_q == ST_ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = wr_q;
  assign pwdata_o  = wd_q;
  assign idle_o    = (st_q == ST_IDLE);
  assign done_o    = (st_q == ST_GAP);
  assign err_o     = err_q;
  assign rdata_o   = rd_q;

endmodule

// File: rtl/apb_irq_master.sv
// APB initiator: arbitrates host commands against automatic IRQ service (read status, write-clear).
module apb_irq_master
  import apb_irq_master_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_ADDR_DEF),
  parameter int                TIMEOUT     = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              auto_en,
  input  logic              irq,
  output logic [3:0]        irq_serviced,
  output logic              svc_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  op_e               op_q, op_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              wr_pend_q, wr_pend_d;

  logic              x_idle, x_done, x_err, x_start, x_write;
  logic [ADDR_W-1:0] x_addr;
  logic [31:0]       x_wdata, x_rdata;
  logic              svc_req;
  logic [PEND_W-1:0] rd_pend;

  assign svc_req = auto_en & irq;
  assign rd_pend = x_rdata[PEND_LSB +: PEND_W];

  // A pending SVC_WR owns the next IDLE slot, keeping the service sequence atomic
  assign x_start   = x_idle & (wr_pend_q | svc_req | cmd_valid);
  assign cmd_ready = x_idle & ~wr_pend_q & ~svc_req & ~reset;

  always_comb begin
    x_write = cmd_write;
    x_addr  = cmd_addr;
    x_wdata = cmd_wdata;
    op_d    = op_q;
    if (wr_pend_q) begin
      x_write = 1'b1;
      x_addr  = STATUS_ADDR;
      x_wdata = {{(32-PEND_W){1'b0}}, pend_q};
    end else if (svc_req) begin
      x_write = 1'b0;
      x_addr  = STATUS_ADDR;
      x_wdata = 32'h0;
    end
    if (x_start)
      op_d = wr_pend_q ? OP_SVC_WR : (svc_req ? OP_SVC_RD : OP_CMD);
  end

  always_comb begin
    pend_d    = pend_q;
    wr_pend_d = wr_pend_q;
    if (x_done && op_q == OP_SVC_RD && !x_err) begin
      pend_d    = rd_pend;
      wr_pend_d = |rd_pend;
    end else if (x_start && wr_pend_q) begin
      wr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_CMD;
      pend_q    <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      pend_q    <= pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  apb_irq_master_xfer #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .pclk      (pclk),
    .reset     (reset),
    .start_i   (x_start),
    .write_i   (x_write),
    .addr_i    (x_addr),
    .wdata_i   (x_wdata),
    .idle_o    (x_idle),
    .done_o    (x_done),
    .err_o     (x_err),
    .rdata_o   (x_rdata),
    .paddr_o   (paddr),
    .pwrite_o  (pwrite),
    .psel_o    (psel),
    .penable_o (penable),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr)
  );

  // Completion pulses all land in the GAP cycle of the finishing transfer
  assign rsp_valid    = x_done & (op_q == OP_CMD);
  assign rsp_rdata    = rsp_valid ? x_rdata : 32'h0;
  assign rsp_err      = rsp_valid & x_err;
  assign irq_serviced = (x_done && op_q == OP_SVC_WR && !x_err) ? pend_q : 4'h0;
  assign svc_err      = x_done & (op_q != OP_CMD) & x_err;

endmodule
